// File: rtl/fir_seq_mac.sv
// Sequential FIR multiply-accumulate for the sample queue's sequencing read stream.
// Each sequence (a run of sequencing strobes) yields one filtered left/right pair.
// Every tap does one MAC against a coefficient read from an external synchronous ROM.
module fir_seq_mac #(
  parameter int unsigned COEFF_AW  = 10,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sequencing,
  input  logic signed [15:0]         lft_in,
  input  logic signed [15:0]         rght_in,
  input  logic signed [15:0]         coeff,
  output logic        [COEFF_AW-1:0] coeff_addr,
  output logic signed [15:0]         lft_filt,
  output logic signed [15:0]         rght_filt,
  output logic                       filt_vld,
  output logic                       tap_ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StFinish} state_e;

  localparam logic [COEFF_AW-1:0]     CntMax = '1;
  localparam logic signed [ACC_W-1:0] SatPos = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SatNeg = ACC_W'(-32768);

  state_e                    state_q;
  logic [COEFF_AW-1:0]       cnt_q;
  logic                      sat_q;
  logic                      seq_q;
  logic                      seq_qq;
  logic signed [ACC_W-1:0]   acc_l_q;
  logic signed [ACC_W-1:0]   acc_r_q;

  logic                      first;
  logic signed [31:0]        prod_l;
  logic signed [31:0]        prod_r;
  logic signed [ACC_W-1:0]   prod_l_ext;
  logic signed [ACC_W-1:0]   prod_r_ext;
  logic signed [15:0]        lft_sat;
  logic signed [15:0]        rght_sat;

  // Shift down to the output scale, truncating, then clamp to 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
    if (s > SatPos) begin
      return 16'sh7fff;
    end else if (s < SatNeg) begin
      return 16'sh8000;
    end
    return s[15:0];
  endfunction

  assign coeff_addr = cnt_q;

  // Products, sign extension, first-tap detect and output formatting.
  always_comb begin
    first      = seq_q & ~seq_qq;
    prod_l     = lft_in * coeff;
    prod_r     = rght_in * coeff;
    prod_l_ext = ACC_W'(prod_l);
    prod_r_ext = ACC_W'(prod_r);
    lft_sat    = sat16(acc_l_q);
    rght_sat   = sat16(acc_r_q);
  end

  // Tap counter, strobe delay line and sticky tap overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      seq_q   <= 1'b0;
      seq_qq  <= 1'b0;
      tap_ovf <= 1'b0;
    end else begin
      seq_q  <= sequencing;
      seq_qq <= seq_q;
      if (!sequencing) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + COEFF_AW'(1);
      end
      // sat_q marks that the last-address tap has already been used, so only a
      // further tap beyond 2^COEFF_AW counts as an overflow.
      sat_q <= sequencing & (cnt_q == CntMax);
      if (sequencing && !seq_q) begin
        tap_ovf <= 1'b0;
      end else if (sequencing && (cnt_q == CntMax) && sat_q) begin
        tap_ovf <= 1'b1;
      end
    end
  end

  // Per-channel accumulate; the first tap loads instead of adding.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else if (seq_q) begin
      acc_l_q <= first ? prod_l_ext : acc_l_q + prod_l_ext;
      acc_r_q <= first ? prod_r_ext : acc_r_q + prod_r_ext;
    end
  end

  // Sequence control and registered results. Transitions look at sequencing,
  // which is next cycle's seq_d, so each state lines up with the seq_d cycle it
  // governs: ACCUM spans the MAC cycles and FINISH is the cycle after the last MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lft_filt  <= '0;
      rght_filt <= '0;
      filt_vld  <= 1'b0;
    end else begin
      filt_vld <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sequencing) state_q <= StAccum;
        end
        StAccum: begin
          if (!sequencing) state_q <= StFinish;
        end
        StFinish: begin
          // Captures the pre-overwrite accumulator even if a new sequence's first
          // MAC lands on this same edge.
          lft_filt  <= lft_sat;
          rght_filt <= rght_sat;
          filt_vld  <= 1'b1;
          state_q   <= sequencing ? StAccum : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Randomized scoreboard bench for fir_seq_mac with a synchronous coefficient ROM model.
module tb_fir_seq_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               sequencing;
  logic signed [15:0] lft_in;
  logic signed [15:0] rght_in;
  logic signed [15:0] coeff;
  logic [9:0]         coeff_addr;
  logic signed [15:0] lft_filt;
  logic signed [15:0] rght_filt;
  logic               filt_vld;
  logic               tap_ovf;

  always #5 clk = ~clk;

  fir_seq_mac dut (
    .clk       (clk),
    .rst       (rst),
    .sequencing(sequencing),
    .lft_in    (lft_in),
    .rght_in   (rght_in),
    .coeff     (coeff),
    .coeff_addr(coeff_addr),
    .lft_filt  (lft_filt),
    .rght_filt (rght_filt),
    .filt_vld  (filt_vld),
    .tap_ovf   (tap_ovf)
  );

  logic signed [15:0] rom [1024];
  always @(posedge clk) coeff <= rom[coeff_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [15:0] l;
    logic signed [15:0] r;
    int                 at;
  } exp_t;
  exp_t sb[$];

  logic signed [15:0] lbuf [1200];
  logic signed [15:0] rbuf [1200];
  logic signed [15:0] pend_l;
  logic signed [15:0] pend_r;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference formatting: arithmetic shift, truncate, clamp.
  function automatic longint fmt(input longint acc);
    longint r;
    r = acc >>> 15;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  // One cycle of stimulus; sample data follows its strobe by one cycle.
  task automatic tick(input bit s, input logic signed [15:0] l, input logic signed [15:0] r);
    sequencing = s;
    lft_in     = pend_l;
    rght_in    = pend_r;
    if (s) begin
      pend_l = l;
      pend_r = r;
    end else begin
      pend_l = 16'($urandom);
      pend_r = 16'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  // Drive an n-tap sequence from lbuf/rbuf followed by gap idle cycles.
  task automatic run_seq(input int n, input int gap);
    longint al = 0;
    longint ar = 0;
    exp_t   e;
    for (int k = 0; k < n; k++) begin
      al += longint'(lbuf[k]) * longint'(rom[(k > 1023) ? 1023 : k]);
      ar += longint'(rbuf[k]) * longint'(rom[(k > 1023) ? 1023 : k]);
    end
    e.l  = 16'(fmt(al));
    e.r  = 16'(fmt(ar));
    e.at = cyc + n + 2;
    sb.push_back(e);
    for (int k = 0; k < n; k++) begin
      check("coeff_addr", coeff_addr, (k > 1023) ? 1023 : k);
      tick(1'b1, lbuf[k], rbuf[k]);
    end
    for (int g = 0; g < gap; g++) tick(1'b0, 16'sd0, 16'sd0);
  endtask

  task automatic fill(input logic signed [15:0] l, input logic signed [15:0] r);
    for (int k = 0; k < 1200; k++) begin
      lbuf[k] = l;
      rbuf[k] = r;
    end
  endtask

  task automatic rom_const(input logic signed [15:0] v);
    for (int k = 0; k < 1024; k++) rom[k] = v;
  endtask

  // Monitor: every filt_vld pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (filt_vld) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_vld: got filt_vld=1 expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lft_filt", lft_filt, e.l);
        check("rght_filt", rght_filt, e.r);
        check("vld_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    sequencing = 1'b0;
    lft_in     = '0;
    rght_in    = '0;
    pend_l     = '0;
    pend_r     = '0;
    rom_const(16'sh4000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_lft", lft_filt, 0);
    check("rst_rght", rght_filt, 0);
    check("rst_vld", filt_vld, 0);
    check("rst_ovf", tap_ovf, 0);
    check("rst_addr", coeff_addr, 0);
    rst = 1'b0;
    tick(1'b0, 16'sd0, 16'sd0);

    // Half-scale coefficients, 4 taps.
    fill(16'sd1000, -16'sd500);
    run_seq(4, 5);
    check("t1_ovf", tap_ovf, 0);
    check("t1_hold_lft", lft_filt, 2000);
    check("t1_hold_rght", rght_filt, -1000);

    // Full scale both polarities: saturates.
    rom_const(16'sh7fff);
    fill(16'sh7fff, 16'sh8000);
    run_seq(10, 5);

    // Ramp ROM, 1021 taps.
    for (int k = 0; k < 1024; k++) rom[k] = 16'(k);
    fill(16'sd1, -16'sd1);
    run_seq(1021, 5);
    check("t3_lft", lft_filt, 15);

    // Back-to-back with a single idle cycle in between.
    rom_const(16'sh4000);
    fill(16'sd1000, -16'sd500);
    run_seq(4, 1);
    fill(16'sd3000, 16'sd700);
    run_seq(4, 5);
    check("t4_lft", lft_filt, 6000);

    // Single-tap sequence.
    fill(-16'sd1234, 16'sd4321);
    run_seq(1, 5);

    // Reset in the middle of a sequence: partial sum dropped, no pulse.
    tick(1'b1, 16'sd1000, -16'sd500);
    tick(1'b1, 16'sd1000, -16'sd500);
    rst = 1'b1;
    tick(1'b0, 16'sd0, 16'sd0);
    rst = 1'b0;
    repeat (6) tick(1'b0, 16'sd0, 16'sd0);
    check("t5_lft", lft_filt, 0);
    check("t5_rght", rght_filt, 0);
    check("t5_addr", coeff_addr, 0);
    check("t5_ovf", tap_ovf, 0);

    // Over-long sequence sets the sticky flag; next sequence clears it.
    for (int k = 0; k < 1200; k++) begin
      lbuf[k] = 16'($signed($urandom_range(2000)) - 1000);
      rbuf[k] = 16'($signed($urandom_range(2000)) - 1000);
    end
    run_seq(1100, 5);
    check("t6_ovf_set", tap_ovf, 1);
    fill(16'sd10, 16'sd20);
    run_seq(3, 5);
    check("t6_ovf_clr", tap_ovf, 0);

    // Random coefficients, data, lengths and gaps.
    for (int k = 0; k < 1024; k++) rom[k] = 16'($urandom);
    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < 64; k++) begin
        lbuf[k] = 16'($urandom);
        rbuf[k] = 16'($urandom);
      end
      run_seq(int'($urandom_range(40, 1)), int'($urandom_range(3, 1)));
    end
    repeat (6) tick(1'b0, 16'sd0, 16'sd0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
